// File: rtl/async_fifo_pkg.sv
// Shared defaults and types for the async FIFO read-side streaming adapter.
package async_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_CNT_WIDTH  = 16;

    // Occupancy of the 2-entry output buffer (0..2).
    typedef logic [1:0] occ_t;

endpackage

// File: rtl/async_fifo_rd_stream_if.sv
// Stream handshake: a beat transfers on a rising clk edge where m_valid and m_ready are both 1;
// once m_valid is raised, m_valid and m_data hold until that transfer, a reset or a flush.
interface async_fifo_rd_stream_if import async_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);

endinterface

// File: rtl/stream_skid_buf2.sv
// Two-entry in-order buffer: tail written on push, head advanced on pop, both allowed in one cycle.
module stream_skid_buf2 import async_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output occ_t                  count
);

    logic [DATA_WIDTH-1:0] mem [2];
    logic                  rd_ptr;
    logic                  wr_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; the head is ignored while count is zero.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/async_fifo_rd_stream.sv
// Turns the async FIFO read port (one-cycle read latency) into a valid/ready stream without bubbles.
module async_fifo_rd_stream import async_fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  flush,
    async_fifo_rd_stream_if.master m,
    output logic [CNT_WIDTH-1:0]  words_out
);

    occ_t                  buf_count;
    logic                  inflight;
    logic                  pop;
    logic [2:0]            occ_after;
    logic [DATA_WIDTH-1:0] head_data;

    assign pop = m.m_valid & m.m_ready;

    // Words held or already requested once this cycle's pop leaves; a read is only
    // issued when its returning word is guaranteed a free buffer slot.
    assign occ_after  = {1'b0, buf_count} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = !fifo_empty && !rst && !flush && (occ_after < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) inflight <= 1'b0;
        else     inflight <= fifo_rd_en;
    end

    // A beat handed over in a flush cycle still completed, so it is counted.
    always_ff @(posedge clk) begin
        if (rst)      words_out <= '0;
        else if (pop) words_out <= words_out + CNT_WIDTH'(1);
    end

    stream_skid_buf2 #(.DATA_WIDTH(DATA_WIDTH)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .head_data (head_data),
        .count     (buf_count)
    );

    assign m.m_valid = (buf_count != 2'd0);
    assign m.m_data  = head_data;

endmodule
